// File: rtl/mngr_pkg.sv
// mngr_pkg: shared widths and message type for the proc2mngr arbiter.
//   MNGR_MSG_W : width of one manager-channel message
//   XFER_CNT_W : width of the output-handshake counter
//   mngr_msg_t : one manager-channel message
package mngr_pkg;

    localparam int MNGR_MSG_W = 32;
    localparam int XFER_CNT_W = 16;

    typedef logic [MNGR_MSG_W-1:0] mngr_msg_t;

endpackage

// File: rtl/mngr_rr_pick.sv
// mngr_rr_pick: combinational round-robin pick.
// The request vector is rotated so that requester `ptr` lands at bit 0.
// The lowest set bit is then found, and the offset is added back to `ptr`
// modulo NREQ.
//   req     in  NREQ  request vector
//   ptr     in  ID_W  highest-priority requester, always < NREQ
//   gnt_val out 1     any request present
//   gnt_idx out ID_W  winning requester, always < NREQ
module mngr_rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic            gnt_val,
    output logic [ID_W-1:0] gnt_idx
);

    localparam int SUM_W = ID_W + 1;

    logic [NREQ-1:0]  rot;
    logic [ID_W-1:0]  off;
    logic [SUM_W-1:0] sum;

    // Shifting a doubled copy right by ptr is a rotate that needs no modulo.
    assign rot     = NREQ'({req, req} >> ptr);
    assign gnt_val = |req;

    always_comb begin
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = ID_W'(k);
            end
        end
    end

    // The subtraction below stands in for a true modulo. It keeps the index
    // inside 0..NREQ-1 when NREQ is not a power of two.
    always_comb begin
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= SUM_W'(NREQ)) begin
            sum = sum - SUM_W'(NREQ);
        end
    end

    assign gnt_idx = sum[ID_W-1:0];

endmodule

// File: rtl/mngr_arb.sv
// mngr_arb: round-robin arbiter that merges NREQ val/rdy requesters onto the
// single proc2mngr manager port through a one-entry output register.
//   clk      in  1            rising-edge clock
//   rst      in  1            asynchronous active-low reset
//   req_val  in  NREQ         per-requester valid
//   req_rdy  out NREQ         per-requester ready, at most one bit high
//   req_msg  in  NREQ*MSG_W   requester i at [i*MSG_W +: MSG_W]
//   out_val  out 1            manager-port valid
//   out_rdy  in  1            manager-port ready
//   out_msg  out MSG_W        buffered message
//   out_src  out ID_W         requester that supplied out_msg
//   xfer_cnt out XFER_CNT_W   completed output handshakes, wrapping
module mngr_arb
    import mngr_pkg::*;
#(
    parameter int  NREQ  = 4,
    parameter int  MSG_W = MNGR_MSG_W,
    localparam int ID_W  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_val,
    output logic [NREQ-1:0]       req_rdy,
    input  logic [NREQ*MSG_W-1:0] req_msg,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [MSG_W-1:0]      out_msg,
    output logic [ID_W-1:0]       out_src,
    output logic [XFER_CNT_W-1:0] xfer_cnt
);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_val;
    logic             can_load;
    logic             in_xfer;
    logic             out_xfer;
    logic [MSG_W-1:0] gnt_msg;

    mngr_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req     (req_val),
        .ptr     (ptr),
        .gnt_val (gnt_val),
        .gnt_idx (gnt_idx)
    );

    // rst is included so that no requester sees ready while reset holds the
    // output stage empty.
    assign can_load = (!out_val || out_rdy) && rst;
    assign in_xfer  = can_load && gnt_val;
    assign out_xfer = out_val && out_rdy;

    always_comb begin
        req_rdy = '0;
        gnt_msg = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                req_rdy[i] = in_xfer;
                gnt_msg    = req_msg[i*MSG_W +: MSG_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_val  <= 1'b0;
            out_msg  <= '0;
            out_src  <= '0;
            ptr      <= '0;
            xfer_cnt <= '0;
        end else begin
            if (in_xfer) begin
                out_val <= 1'b1;
                out_msg <= gnt_msg;
                out_src <= gnt_idx;
                ptr     <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            end else if (out_xfer) begin
                out_val <= 1'b0;
            end
            if (out_xfer) begin
                xfer_cnt <= xfer_cnt + XFER_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mngr_arb.sv
`timescale 1ns/1ps
module tb_mngr_arb;
    import mngr_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // NREQ=4 instance
    logic [3:0]   val4;
    logic [3:0]   rdy4;
    logic         ordy4;
    mngr_msg_t    m4 [4];
    logic [127:0] msg4;
    logic         ov4;
    mngr_msg_t    om4;
    logic [1:0]   os4;
    logic [15:0]  cnt4;
    assign msg4 = {m4[3], m4[2], m4[1], m4[0]};

    // NREQ=3 instance
    logic [2:0]   val3;
    logic [2:0]   rdy3;
    logic         ordy3;
    logic [95:0]  msg3;
    logic         ov3;
    mngr_msg_t    om3;
    logic [1:0]   os3;
    logic [15:0]  cnt3;

    mngr_arb #(.NREQ(4)) dut (
        .clk(clk), .rst(rst), .req_val(val4), .req_rdy(rdy4), .req_msg(msg4),
        .out_val(ov4), .out_rdy(ordy4), .out_msg(om4), .out_src(os4), .xfer_cnt(cnt4)
    );

    mngr_arb #(.NREQ(3)) dut3 (
        .clk(clk), .rst(rst), .req_val(val3), .req_rdy(rdy3), .req_msg(msg3),
        .out_val(ov3), .out_rdy(ordy3), .out_msg(om3), .out_src(os3), .xfer_cnt(cnt3)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model of the NREQ=4 instance plus the scoreboard queue.
    typedef struct { int src; mngr_msg_t msg; } ent_t;
    ent_t sb[$];
    int   m_ptr;
    bit   m_oval;
    int   m_cnt;

    function automatic int rr_win(logic [3:0] v, int p);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = (p + k) % 4;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_rdy4();
        int w;
        w = rr_win(val4, m_ptr);
        if (w >= 0 && (!m_oval || ordy4)) return 4'(1) << w;
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_oval = 1'b0;
        m_cnt  = 0;
        sb.delete();
    endtask

    // Drive one cycle's inputs on the falling edge; mi >= 0 also updates m4[mi].
    task automatic drive4(input logic [3:0] v, input logic r, input int mi, input mngr_msg_t mv);
        @(negedge clk);
        if (mi >= 0) m4[mi] = mv;
        val4  = v;
        ordy4 = r;
        #1;
    endtask

    // Advance the model across the coming rising edge.
    task automatic adv4();
        int w;
        bit ld, dr;
        w  = rr_win(val4, m_ptr);
        ld = (w >= 0) && (!m_oval || ordy4);
        dr = m_oval && ordy4;
        if (dr) begin
            void'(sb.pop_front());
            m_cnt = (m_cnt + 1) & 16'hFFFF;
        end
        if (ld) begin
            sb.push_back('{src: w, msg: m4[w]});
            m_oval = 1'b1;
            m_ptr  = (w == 3) ? 0 : w + 1;
        end else if (dr) begin
            m_oval = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        val4 = 4'hF; ordy4 = 1'b1;
        val3 = 3'h7; ordy3 = 1'b1;
        #12;
        n_chk++; if (ov4 !== 1'b0)      begin n_fail++; $display("FAIL reset_out_val got %0b want 0", ov4); end
        n_chk++; if (om4 !== 32'h0)     begin n_fail++; $display("FAIL reset_out_msg got %h want 0", om4); end
        n_chk++; if (os4 !== 2'd0)      begin n_fail++; $display("FAIL reset_out_src got %0d want 0", os4); end
        n_chk++; if (cnt4 !== 16'h0)    begin n_fail++; $display("FAIL reset_xfer_cnt got %h want 0", cnt4); end
        n_chk++; if (rdy4 !== 4'b0000)  begin n_fail++; $display("FAIL reset_req_rdy got %b want 0000", rdy4); end
        n_chk++; if (rdy3 !== 3'b000)   begin n_fail++; $display("FAIL reset_req_rdy3 got %b want 000", rdy3); end
        n_chk++; if (ov3 !== 1'b0)      begin n_fail++; $display("FAIL reset_out_val3 got %0b want 0", ov3); end
        @(negedge clk);
        val4 = 4'h0; val3 = 3'h0;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_round_robin();
        logic [1:0] rr_src [8];
        int n_out;
        rr_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        n_out = 0;
        for (int i = 0; i < 4; i++) m4[i] = 32'h100 + i;
        for (int c = 0; c < 10; c++) begin
            drive4((c < 8) ? 4'hF : 4'h0, 1'b1, -1, '0);
            n_chk++; if (ov4 !== m_oval)     begin n_fail++; $display("FAIL rr_out_val c=%0d got %0b want %0b", c, ov4, m_oval); end
            n_chk++; if (rdy4 !== exp_rdy4()) begin n_fail++; $display("FAIL rr_req_rdy c=%0d got %b want %b", c, rdy4, exp_rdy4()); end
            if (m_oval && sb.size() > 0) begin
                n_chk++;
                if (om4 !== sb[0].msg || os4 !== 2'(sb[0].src) || os4 !== rr_src[n_out] || om4 !== 32'h100 + 32'(rr_src[n_out]))
                begin n_fail++; $display("FAIL rr_output n=%0d got src %0d msg %h want src %0d msg %h", n_out, os4, om4, rr_src[n_out], 32'h100 + 32'(rr_src[n_out])); end
                n_out++;
            end
            adv4();
        end
        @(negedge clk);
        n_chk++; if (n_out != 8)     begin n_fail++; $display("FAIL rr_output_count got %0d want 8", n_out); end
        n_chk++; if (cnt4 !== 16'd8) begin n_fail++; $display("FAIL rr_xfer_cnt got %0d want 8", cnt4); end
    endtask

    task automatic test_single_source();
        for (int c = 0; c < 5; c++) begin
            if (c < 3) drive4(4'b0100, 1'b1, 2, 32'hA + c);
            else       drive4(4'b0000, 1'b1, -1, '0);
            n_chk++; if (rdy4 !== exp_rdy4()) begin n_fail++; $display("FAIL single_req_rdy c=%0d got %b want %b", c, rdy4, exp_rdy4()); end
            if (c >= 1 && c <= 3) begin
                n_chk++;
                if (ov4 !== 1'b1 || os4 !== 2'd2 || om4 !== 32'hA + c - 1 || om4 !== sb[0].msg)
                begin n_fail++; $display("FAIL single_output c=%0d got val %0b src %0d msg %h want val 1 src 2 msg %h", c, ov4, os4, om4, 32'hA + c - 1); end
            end
            adv4();
        end
        // Pointer should now sit at 3: with everyone requesting, 3 wins.
        drive4(4'hF, 1'b1, 3, 32'h103);
        n_chk++; if (rdy4 !== 4'b1000) begin n_fail++; $display("FAIL single_ptr_after got rdy %b want 1000", rdy4); end
        adv4();
        drive4(4'h0, 1'b1, -1, '0);
        n_chk++; if (ov4 !== 1'b1 || os4 !== 2'd3 || om4 !== 32'h103) begin n_fail++; $display("FAIL single_ptr_output got src %0d msg %h want src 3 msg 103", os4, om4); end
        adv4();
    endtask

    task automatic test_backpressure();
        logic [15:0] cnt0;
        drive4(4'b0010, 1'b0, 1, 32'h55);
        n_chk++; if (rdy4 !== 4'b0010) begin n_fail++; $display("FAIL bp_load_rdy got %b want 0010", rdy4); end
        cnt0 = cnt4;
        adv4();
        for (int c = 0; c < 5; c++) begin
            drive4(4'hF, 1'b0, -1, '0);
            n_chk++;
            if (ov4 !== 1'b1 || om4 !== 32'h55 || os4 !== 2'd1)
            begin n_fail++; $display("FAIL bp_hold c=%0d got val %0b src %0d msg %h want val 1 src 1 msg 55", c, ov4, os4, om4); end
            n_chk++; if (rdy4 !== 4'b0000) begin n_fail++; $display("FAIL bp_req_rdy c=%0d got %b want 0000", c, rdy4); end
            n_chk++; if (cnt4 !== cnt0)    begin n_fail++; $display("FAIL bp_cnt_hold c=%0d got %0d want %0d", c, cnt4, cnt0); end
            adv4();
        end
        drive4(4'h0, 1'b1, -1, '0);
        n_chk++; if (ov4 !== 1'b1 || om4 !== sb[0].msg || om4 !== 32'h55) begin n_fail++; $display("FAIL bp_release got val %0b msg %h want val 1 msg 55", ov4, om4); end
        adv4();
        drive4(4'h0, 1'b1, -1, '0);
        n_chk++; if (ov4 !== 1'b0)           begin n_fail++; $display("FAIL bp_after_val got %0b want 0", ov4); end
        n_chk++; if (cnt4 !== cnt0 + 16'd1)  begin n_fail++; $display("FAIL bp_after_cnt got %0d want %0d", cnt4, cnt0 + 16'd1); end
        adv4();
    endtask

    task automatic test_nreq3();
        logic [1:0] exp_src [7];
        logic [2:0] exp_r;
        exp_src = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
        msg3 = {32'h302, 32'h301, 32'h300};
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            val3  = (c < 7) ? 3'b111 : 3'b000;
            ordy3 = 1'b1;
            #1;
            exp_r = (c < 7) ? (3'(1) << exp_src[c]) : 3'b000;
            n_chk++; if (rdy3 !== exp_r) begin n_fail++; $display("FAIL n3_req_rdy c=%0d got %b want %b", c, rdy3, exp_r); end
            if (c >= 1 && c <= 7) begin
                n_chk++;
                if (ov3 !== 1'b1 || os3 !== exp_src[c-1] || om3 !== 32'h300 + 32'(exp_src[c-1]))
                begin n_fail++; $display("FAIL n3_output c=%0d got val %0b src %0d msg %h want src %0d", c, ov3, os3, om3, exp_src[c-1]); end
            end
            n_chk++; if (dut3.ptr === 2'd3) begin n_fail++; $display("FAIL n3_ptr_range c=%0d got 3 want <3", c); end
            @(posedge clk);
        end
        @(negedge clk);
        n_chk++; if (cnt3 !== 16'd7 || ov3 !== 1'b0) begin n_fail++; $display("FAIL n3_final got cnt %0d val %0b want cnt 7 val 0", cnt3, ov3); end
    endtask

    task automatic test_reset_mid();
        drive4(4'b0001, 1'b0, 0, 32'h77);
        n_chk++; if (rdy4 !== exp_rdy4() || rdy4 !== 4'b0001) begin n_fail++; $display("FAIL mid_load_rdy got %b want 0001", rdy4); end
        adv4();
        drive4(4'h0, 1'b0, -1, '0);
        n_chk++; if (ov4 !== 1'b1 || om4 !== 32'h77) begin n_fail++; $display("FAIL mid_buffered got val %0b msg %h want val 1 msg 77", ov4, om4); end
        #2;
        rst   = 1'b0;
        ordy4 = 1'b1;
        #1;
        n_chk++; if (ov4 !== 1'b0 || om4 !== 32'h0 || os4 !== 2'd0) begin n_fail++; $display("FAIL mid_reset_out got val %0b msg %h src %0d want 0 0 0", ov4, om4, os4); end
        n_chk++; if (cnt4 !== 16'h0 || rdy4 !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_cnt_rdy got cnt %0d rdy %b want 0 0000", cnt4, rdy4); end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        drive4(4'hF, 1'b1, 0, 32'h70);
        n_chk++; if (rdy4 !== 4'b0001 || rdy4 !== exp_rdy4()) begin n_fail++; $display("FAIL mid_first_grant got %b want 0001", rdy4); end
        adv4();
        drive4(4'h0, 1'b1, -1, '0);
        n_chk++;
        if (ov4 !== 1'b1 || om4 !== 32'h70 || os4 !== 2'd0 || om4 !== sb[0].msg)
        begin n_fail++; $display("FAIL mid_first_output got val %0b src %0d msg %h want val 1 src 0 msg 70", ov4, os4, om4); end
        adv4();
    endtask

    task automatic test_wrap();
        int loads_left;
        int budget;
        for (int phase = 0; phase < 2; phase++) begin
            loads_left = (phase == 0) ? (16'hFFFE - m_cnt - int'(m_oval)) : 3;
            budget = 0;
            while ((loads_left > 0 || m_oval) && budget < 70000) begin
                drive4((loads_left > 0) ? 4'hF : 4'h0, 1'b1, -1, '0);
                n_chk++; if (rdy4 !== exp_rdy4()) begin n_fail++; $display("FAIL wrap_req_rdy cnt=%0d got %b want %b", m_cnt, rdy4, exp_rdy4()); end
                if (m_oval && sb.size() > 0) begin
                    n_chk++;
                    if (ov4 !== 1'b1 || om4 !== sb[0].msg || os4 !== 2'(sb[0].src))
                    begin n_fail++; $display("FAIL wrap_output cnt=%0d got src %0d msg %h want src %0d msg %h", m_cnt, os4, om4, sb[0].src, sb[0].msg); end
                end
                if (exp_rdy4() != 4'b0000) loads_left--;
                adv4();
                budget++;
            end
            n_chk++; if (budget >= 70000) begin n_fail++; $display("FAIL wrap_timeout phase=%0d got %0d cycles want <70000", phase, budget); end
            @(negedge clk);
            if (phase == 0) begin
                n_chk++; if (cnt4 !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_preload got %h want fffe", cnt4); end
            end else begin
                n_chk++; if (cnt4 !== 16'h0001 || cnt4 !== 16'(m_cnt)) begin n_fail++; $display("FAIL wrap_final got %h want 0001", cnt4); end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        val4 = 4'h0; ordy4 = 1'b0;
        val3 = 3'h0; ordy3 = 1'b0;
        msg3 = '0;
        for (int i = 0; i < 4; i++) m4[i] = '0;
        model_reset();
        test_reset();
        test_round_robin();
        test_single_source();
        test_backpressure();
        test_nreq3();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mngr_arb.md
# mngr_arb

Round-robin arbiter that shares the single proc2mngr manager channel among `NREQ` processor-side requesters. Each requester drives a val/rdy message port; the block grants one per cycle, registers the winning message in a one-entry output stage, and presents it with its source ID on the shared manager port. It sits between the core array and the manager endpoint. Every core reports results and flags through the one test-manager channel.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `MSG_W`, 32: message width.
- `ID_W`, `$clog2(NREQ)`: source-ID width, derived, not overridden.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_val`  in  NREQ  per-requester valid.
- `req_rdy`  out  NREQ  per-requester ready.
- `req_msg`  in  NREQ*MSG_W  flattened messages; requester i occupies bits [i*MSG_W +: MSG_W].
- `out_val`  out  1  shared-port valid.
- `out_rdy`  in  1  shared-port ready, driven by the manager.
- `out_msg`  out  MSG_W  granted message.
- `out_src`  out  ID_W  index of the requester that supplied `out_msg`.
- `xfer_cnt`  out  16  count of completed output handshakes; wraps.

## Operation
- Handshake rule: a transfer occurs on any cycle where val && rdy, sampled at the rising clock edge. Valid must never depend on ready. `req_rdy` may depend on `req_val`.
- Output stage: one entry. The state is `out_val`, `out_msg` and `out_src`.
  - `can_load = !out_val || out_rdy`. This permits a load in the same cycle the current entry drains.
- Arbitration: round-robin pointer `ptr`, ID_W bits.
  - Requester priority order is `ptr`, `ptr+1`, …, wrapping modulo `NREQ`.
  - The winner is the first requester with `req_val=1` in that order.
  - `req_rdy[i] = can_load && (winner == i)`. At most one `req_rdy` bit is high.
- On an input transfer from winner w:
  - `out_msg <= req_msg[w]`, `out_src <= w`, `out_val <= 1`.
  - `ptr <= (w == NREQ-1) ? 0 : w+1`.
- On an output transfer with no input transfer in the same cycle: `out_val <= 0`. `out_msg` and `out_src` hold their values.
- `xfer_cnt` increments by 1 on every output transfer and wraps 0xFFFF -> 0x0000.
- When no requester is valid: `ptr` holds and `req_rdy` is all 0.

## Timing
- Reset values, applied asynchronously while `rst=0`:
  - `out_val=0`, `out_msg=0`, `out_src=0`, `ptr=0`, `xfer_cnt=0`.
  - `req_rdy=0`, because `req_rdy` is gated by the reset-held state and forced low during reset.
- Latency: an input transfer in cycle n gives `out_val=1` with that message in cycle n+1.
- Throughput: one message per cycle with `out_rdy` held high, including back-to-back messages from the same or from different requesters.
- Backpressure: while `out_val=1` and `out_rdy=0`, the following hold stable and `req_rdy` is all 0:
  - `out_val`, `out_msg`, `out_src`
  - `ptr`
- Simultaneous drain and load: the output entry is replaced, `out_val` stays 1, and `xfer_cnt` increments.
- Fairness: a requester that holds `req_val=1` is granted within `NREQ` input transfers.
- Non-power-of-two `NREQ`: `ptr` never takes values ≥ `NREQ`. Indices ≥ `NREQ` are never granted.
- Reset asserted mid-operation: a buffered message is discarded without a handshake and the pointer returns to 0. Deassertion is synchronised externally.

## Structure
- Package `mngr_pkg`:
  - `MNGR_MSG_W = 32`
  - `typedef logic [MNGR_MSG_W-1:0] mngr_msg_t`
  - `XFER_CNT_W = 16`
- Sub-module `mngr_rr_pick`: combinational pick logic.
  - Inputs: `req` [NREQ] and `ptr`.
  - Outputs: `gnt_val` and `gnt_idx`.
  - Implemented as a rotate, priority-encode, then un-rotate.
  - `mngr_arb` owns all registers.

## Test plan
- Reset, then all `req_val=1` with `req_msg[i]=0x100+i` and `out_rdy=1` for 8 cycles. Required output sequence:
  - `out_src` = 0,1,2,3,0,1,2,3
  - `out_msg` = 0x100, 0x101, …
  - `xfer_cnt` = 8
- Only requester 2 valid, for 3 consecutive messages 0xA, 0xB, 0xC. Required: three back-to-back outputs from source 2 with no bubble, and `ptr` = 3 afterwards.
- Load 0x55 from requester 1, then hold `out_rdy=0` for 5 cycles. Required:
  - `out_msg=0x55` and `out_src=1` remain stable.
  - `req_rdy=0`.
  - After `out_rdy` rises, exactly one transfer of 0x55 occurs.
- `NREQ=3` build, all requesters valid for 7 transfers. Required: `out_src` = 0,1,2,0,1,2,0; pointer value 3 is never observed.
- Assert `rst=0` mid-cycle while `out_val=1` holding 0x77. Required: `out_val` drops immediately, 0x77 is never handed over, and after release the first grant goes to requester 0.
- Preload `xfer_cnt` to 0xFFFE by running 65534 transfers, then perform 3 more. Required: `xfer_cnt` = 0x0001.
